// File: rtl/cc_regbank_pkg.sv
// cc_regbank_pkg
// Shared definitions for the register bank, operand mux and control unit.
//   - reg_sel_e : 4-bit register select codes (g0..g7, PC, Temp0..Temp3, IR).
//     Codes 4'hE and 4'hF are unused.
//   - bus width, select width and PC step defaults.
package cc_regbank_pkg;

  localparam int CC_DATAWIDTH_BUS           = 32;
  localparam int CC_DATAWIDTH_REG_SELECTION = 4;
  localparam int CC_PC_STEP                 = 4;

  typedef enum logic [3:0] {
    REG_G0    = 4'h0,
    REG_G1    = 4'h1,
    REG_G2    = 4'h2,
    REG_G3    = 4'h3,
    REG_G4    = 4'h4,
    REG_G5    = 4'h5,
    REG_G6    = 4'h6,
    REG_G7    = 4'h7,
    REG_PC    = 4'h8,
    REG_TEMP0 = 4'h9,
    REG_TEMP1 = 4'hA,
    REG_TEMP2 = 4'hB,
    REG_TEMP3 = 4'hC,
    REG_IR    = 4'hD
  } reg_sel_e;

endpackage

// File: rtl/cc_register_bank_cell.sv
// cc_reg_cell
// One bus-wide register with synchronous active-high reset and load enable.
//   i_clk   : rising-edge clock
//   i_rst   : synchronous reset, loads RESET_VALUE
//   i_load  : capture i_d on this edge
//   i_d     : next value
//   o_q     : registered value
module cc_reg_cell #(
  parameter int                 DATAWIDTH_BUS = 32,
  parameter logic [DATAWIDTH_BUS-1:0] RESET_VALUE = '0
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_load,
  input  logic [DATAWIDTH_BUS-1:0] i_d,
  output logic [DATAWIDTH_BUS-1:0] o_q
);

  logic [DATAWIDTH_BUS-1:0] r_q;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_q <= RESET_VALUE;
    end else if (i_load) begin
      r_q <= i_d;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/cc_register_bank.sv
// cc_register_bank
// Architectural/scratch register storage feeding the 14-input operand mux.
// Inputs : clock, sync active-high reset, C-bus write (data, select, enable),
//          PC increment, IR fetch-load (memory data), Temp clear.
// Outputs: g0..g7, PC, Temp0..Temp3, IR as parallel register buses, plus
//          WriteAck (a C-bus write was committed on the last edge).
// Write semantics: WriteEn is a single-cycle request with no back-pressure;
// WriteAck is its registered commit indication, high for one cycle after an
// edge on which the addressed register actually took CBus_In.
// Every output is a flop output; there is no CBus bypass.
module cc_register_bank
  import cc_regbank_pkg::*;
#(
  parameter int                       DATAWIDTH_BUS           = CC_DATAWIDTH_BUS,
  parameter int                       DATAWIDTH_REG_SELECTION = CC_DATAWIDTH_REG_SELECTION,
  parameter logic [DATAWIDTH_BUS-1:0] PC_RESET_VALUE          = '0,
  parameter int                       PC_STEP                 = CC_PC_STEP
) (
  input  logic                               CC_REGBANK_CLOCK_50,
  input  logic                               CC_REGBANK_RESET_InHigh,
  input  logic [DATAWIDTH_BUS-1:0]           CC_REGBANK_CBus_In,
  input  logic [DATAWIDTH_REG_SELECTION-1:0] CC_REGBANK_WriteSel_In,
  input  logic                               CC_REGBANK_WriteEn_In,
  input  logic                               CC_REGBANK_PCInc_In,
  input  logic                               CC_REGBANK_IRLoad_In,
  input  logic [DATAWIDTH_BUS-1:0]           CC_REGBANK_MemData_In,
  input  logic                               CC_REGBANK_TempClear_In,
  output logic [DATAWIDTH_BUS-1:0]           CC_REGBANK_g0_Out,
  output logic [DATAWIDTH_BUS-1:0]           CC_REGBANK_g1_Out,
  output logic [DATAWIDTH_BUS-1:0]           CC_REGBANK_g2_Out,
  output logic [DATAWIDTH_BUS-1:0]           CC_REGBANK_g3_Out,
  output logic [DATAWIDTH_BUS-1:0]           CC_REGBANK_g4_Out,
  output logic [DATAWIDTH_BUS-1:0]           CC_REGBANK_g5_Out,
  output logic [DATAWIDTH_BUS-1:0]           CC_REGBANK_g6_Out,
  output logic [DATAWIDTH_BUS-1:0]           CC_REGBANK_g7_Out,
  output logic [DATAWIDTH_BUS-1:0]           CC_REGBANK_PC_Out,
  output logic [DATAWIDTH_BUS-1:0]           CC_REGBANK_Temp0_Out,
  output logic [DATAWIDTH_BUS-1:0]           CC_REGBANK_Temp1_Out,
  output logic [DATAWIDTH_BUS-1:0]           CC_REGBANK_Temp2_Out,
  output logic [DATAWIDTH_BUS-1:0]           CC_REGBANK_Temp3_Out,
  output logic [DATAWIDTH_BUS-1:0]           CC_REGBANK_IR_Out,
  output logic                               CC_REGBANK_WriteAck_Out
);

  localparam int NUM_CODES = 1 << DATAWIDTH_REG_SELECTION;

  // One-hot of the addressed register when WriteEn is high.
  logic [NUM_CODES-1:0]     w_wr_dec;
  logic                     w_wr_commit;
  logic                     w_ir_conflict;
  logic [DATAWIDTH_BUS-1:0] w_g    [0:7];
  logic [DATAWIDTH_BUS-1:0] w_temp [0:3];
  logic [DATAWIDTH_BUS-1:0] w_pc;
  logic [DATAWIDTH_BUS-1:0] w_ir;
  logic [DATAWIDTH_BUS-1:0] w_pc_next;
  logic [DATAWIDTH_BUS-1:0] w_ir_next;
  logic                     r_write_ack;

  always_comb begin
    w_wr_dec = '0;
    w_wr_dec[CC_REGBANK_WriteSel_In] = CC_REGBANK_WriteEn_In;
  end

  // Only g1..IR accept writes; g0 and the two unused codes drop silently.
  assign w_wr_commit = CC_REGBANK_WriteEn_In
                    && (CC_REGBANK_WriteSel_In != DATAWIDTH_REG_SELECTION'(REG_G0))
                    && (CC_REGBANK_WriteSel_In <= DATAWIDTH_REG_SELECTION'(REG_IR));

  // IR fetch wins over a same-cycle C-bus write to IR, and that write is not acked.
  assign w_ir_conflict = w_wr_dec[int'(REG_IR)] && CC_REGBANK_IRLoad_In;

  // g0 is a constant, not storage.
  assign w_g[0] = '0;

  for (genvar gi = 1; gi < 8; gi++) begin : g_gen
    cc_reg_cell #(
      .DATAWIDTH_BUS (DATAWIDTH_BUS),
      .RESET_VALUE   ('0)
    ) u_cell (
      .i_clk  (CC_REGBANK_CLOCK_50),
      .i_rst  (CC_REGBANK_RESET_InHigh),
      .i_load (w_wr_dec[gi]),
      .i_d    (CC_REGBANK_CBus_In),
      .o_q    (w_g[gi])
    );
  end

  // PC: C-bus write > increment > hold. Increment wraps at the bus width.
  assign w_pc_next = w_wr_dec[int'(REG_PC)] ? CC_REGBANK_CBus_In
                                            : (w_pc + DATAWIDTH_BUS'(PC_STEP));

  cc_reg_cell #(
    .DATAWIDTH_BUS (DATAWIDTH_BUS),
    .RESET_VALUE   (PC_RESET_VALUE)
  ) u_pc (
    .i_clk  (CC_REGBANK_CLOCK_50),
    .i_rst  (CC_REGBANK_RESET_InHigh),
    .i_load (w_wr_dec[int'(REG_PC)] || CC_REGBANK_PCInc_In),
    .i_d    (w_pc_next),
    .o_q    (w_pc)
  );

  // Temps: C-bus write > clear > hold. Clear only touches unwritten temps.
  for (genvar ti = 0; ti < 4; ti++) begin : temp_gen
    cc_reg_cell #(
      .DATAWIDTH_BUS (DATAWIDTH_BUS),
      .RESET_VALUE   ('0)
    ) u_cell (
      .i_clk  (CC_REGBANK_CLOCK_50),
      .i_rst  (CC_REGBANK_RESET_InHigh),
      .i_load (w_wr_dec[int'(REG_TEMP0) + ti] || CC_REGBANK_TempClear_In),
      .i_d    (w_wr_dec[int'(REG_TEMP0) + ti] ? CC_REGBANK_CBus_In : '0),
      .o_q    (w_temp[ti])
    );
  end

  // IR: fetch-load > C-bus write > hold.
  assign w_ir_next = CC_REGBANK_IRLoad_In ? CC_REGBANK_MemData_In : CC_REGBANK_CBus_In;

  cc_reg_cell #(
    .DATAWIDTH_BUS (DATAWIDTH_BUS),
    .RESET_VALUE   ('0)
  ) u_ir (
    .i_clk  (CC_REGBANK_CLOCK_50),
    .i_rst  (CC_REGBANK_RESET_InHigh),
    .i_load (CC_REGBANK_IRLoad_In || w_wr_dec[int'(REG_IR)]),
    .i_d    (w_ir_next),
    .o_q    (w_ir)
  );

  always_ff @(posedge CC_REGBANK_CLOCK_50) begin
    if (CC_REGBANK_RESET_InHigh) begin
      r_write_ack <= 1'b0;
    end else begin
      r_write_ack <= w_wr_commit && !w_ir_conflict;
    end
  end

  assign CC_REGBANK_g0_Out       = w_g[0];
  assign CC_REGBANK_g1_Out       = w_g[1];
  assign CC_REGBANK_g2_Out       = w_g[2];
  assign CC_REGBANK_g3_Out       = w_g[3];
  assign CC_REGBANK_g4_Out       = w_g[4];
  assign CC_REGBANK_g5_Out       = w_g[5];
  assign CC_REGBANK_g6_Out       = w_g[6];
  assign CC_REGBANK_g7_Out       = w_g[7];
  assign CC_REGBANK_PC_Out       = w_pc;
  assign CC_REGBANK_Temp0_Out    = w_temp[0];
  assign CC_REGBANK_Temp1_Out    = w_temp[1];
  assign CC_REGBANK_Temp2_Out    = w_temp[2];
  assign CC_REGBANK_Temp3_Out    = w_temp[3];
  assign CC_REGBANK_IR_Out       = w_ir;
  assign CC_REGBANK_WriteAck_Out = r_write_ack;

endmodule

// File: tb/tb_cc_register_bank.sv
// tb_cc_register_bank
// Directed test-plan steps followed by randomized cycles, all checked against
// a reference model that holds the 14 architectural values indexed by their
// select code (0..7 = g, 8 = PC, 9..12 = Temp, 13 = IR).
module tb_cc_register_bank;

  localparam int          W      = 32;
  localparam logic [31:0] PC_RST = 32'h0000_0100;

  // Clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [31:0] cbus;
  logic [3:0]  sel;
  logic        we;
  logic        pcinc;
  logic        irload;
  logic [31:0] mem;
  logic        tclr;

  logic [31:0] o_g0, o_g1, o_g2, o_g3, o_g4, o_g5, o_g6, o_g7;
  logic [31:0] o_pc, o_t0, o_t1, o_t2, o_t3, o_ir;
  logic        o_ack;

  cc_register_bank #(
    .DATAWIDTH_BUS           (W),
    .DATAWIDTH_REG_SELECTION (4),
    .PC_RESET_VALUE          (PC_RST),
    .PC_STEP                 (4)
  ) dut (
    .CC_REGBANK_CLOCK_50     (clk),
    .CC_REGBANK_RESET_InHigh (rst),
    .CC_REGBANK_CBus_In      (cbus),
    .CC_REGBANK_WriteSel_In  (sel),
    .CC_REGBANK_WriteEn_In   (we),
    .CC_REGBANK_PCInc_In     (pcinc),
    .CC_REGBANK_IRLoad_In    (irload),
    .CC_REGBANK_MemData_In   (mem),
    .CC_REGBANK_TempClear_In (tclr),
    .CC_REGBANK_g0_Out       (o_g0),
    .CC_REGBANK_g1_Out       (o_g1),
    .CC_REGBANK_g2_Out       (o_g2),
    .CC_REGBANK_g3_Out       (o_g3),
    .CC_REGBANK_g4_Out       (o_g4),
    .CC_REGBANK_g5_Out       (o_g5),
    .CC_REGBANK_g6_Out       (o_g6),
    .CC_REGBANK_g7_Out       (o_g7),
    .CC_REGBANK_PC_Out       (o_pc),
    .CC_REGBANK_Temp0_Out    (o_t0),
    .CC_REGBANK_Temp1_Out    (o_t1),
    .CC_REGBANK_Temp2_Out    (o_t2),
    .CC_REGBANK_Temp3_Out    (o_t3),
    .CC_REGBANK_IR_Out       (o_ir),
    .CC_REGBANK_WriteAck_Out (o_ack)
  );

  logic [31:0] obs [14];
  assign obs[0]  = o_g0;
  assign obs[1]  = o_g1;
  assign obs[2]  = o_g2;
  assign obs[3]  = o_g3;
  assign obs[4]  = o_g4;
  assign obs[5]  = o_g5;
  assign obs[6]  = o_g6;
  assign obs[7]  = o_g7;
  assign obs[8]  = o_pc;
  assign obs[9]  = o_t0;
  assign obs[10] = o_t1;
  assign obs[11] = o_t2;
  assign obs[12] = o_t3;
  assign obs[13] = o_ir;

  // Scoreboard state
  logic [31:0] m_reg [14];
  logic        m_ack;
  int          n_tests = 0;
  int          n_fail  = 0;

  // Reference model: apply one clock edge's worth of rules to m_reg/m_ack.
  task automatic model_edge();
    logic [31:0] nxt [14];
    bit          wrote [14];
    for (int i = 0; i < 14; i++) begin
      nxt[i]   = m_reg[i];
      wrote[i] = 1'b0;
    end
    if (rst) begin
      for (int i = 0; i < 14; i++) nxt[i] = 32'h0;
      nxt[8] = PC_RST;
      m_ack  = 1'b0;
    end else begin
      m_ack = 1'b0;
      if (we && sel >= 4'd1 && sel <= 4'd13) begin
        nxt[sel]   = cbus;
        wrote[sel] = 1'b1;
        m_ack      = 1'b1;
      end
      if (pcinc && !wrote[8]) nxt[8] = m_reg[8] + 32'd4;
      if (tclr) begin
        for (int i = 9; i <= 12; i++) if (!wrote[i]) nxt[i] = 32'h0;
      end
      if (irload) begin
        nxt[13] = mem;
        if (wrote[13]) m_ack = 1'b0;
      end
    end
    for (int i = 0; i < 14; i++) m_reg[i] = nxt[i];
  endtask

  task automatic check_all(input string tag);
    for (int i = 0; i < 14; i++) begin
      n_tests++;
      assert (obs[i] === m_reg[i]) else begin
        n_fail++;
        $error("FAIL %s reg%0d observed %h expected %h", tag, i, obs[i], m_reg[i]);
      end
    end
    n_tests++;
    assert (o_ack === m_ack) else begin
      n_fail++;
      $error("FAIL %s ack observed %b expected %b", tag, o_ack, m_ack);
    end
  endtask

  // Check against a literal value taken from the test plan.
  task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_tests++;
    assert (observed === expected) else begin
      n_fail++;
      $error("FAIL %s observed %h expected %h", tag, observed, expected);
    end
  endtask

  // Driver: present inputs, clock one edge, update model, check #1 after edge.
  task automatic drive(input string tag, input logic r, input logic w, input logic [3:0] s,
                       input logic [31:0] d, input logic pi, input logic il,
                       input logic [31:0] md, input logic tc);
    rst = r; we = w; sel = s; cbus = d; pcinc = pi; irload = il; mem = md; tclr = tc;
    @(posedge clk);
    model_edge();
    #1;
    check_all(tag);
  endtask

  initial begin
    rst = 1'b1; we = 1'b0; sel = 4'h0; cbus = '0; pcinc = 1'b0;
    irload = 1'b0; mem = '0; tclr = 1'b0;
    for (int i = 0; i < 14; i++) m_reg[i] = 32'h0;
    m_ack = 1'b0;

    // Reset for two cycles
    drive("reset0", 1, 0, 4'h0, 32'h0, 0, 0, 32'h0, 0);
    drive("reset1", 1, 0, 4'h0, 32'h0, 0, 0, 32'h0, 0);
    chk("reset_pc", o_pc, 32'h0000_0100);
    chk("reset_ack", {31'b0, o_ack}, 32'h0);

    // Write / readback
    drive("wr_g5", 0, 1, 4'h5, 32'hDEAD_BEEF, 0, 0, 32'h0, 0);
    chk("wr_g5_val", o_g5, 32'hDEAD_BEEF);
    chk("wr_g5_ack", {31'b0, o_ack}, 32'h1);
    drive("wr_t1", 0, 1, 4'hA, 32'h1234_5678, 0, 0, 32'h0, 0);
    chk("wr_t1_val", o_t1, 32'h1234_5678);
    chk("wr_t1_ack", {31'b0, o_ack}, 32'h1);

    // g0 and unused codes
    drive("wr_g0", 0, 1, 4'h0, 32'hFFFF_FFFF, 0, 0, 32'h0, 0);
    chk("wr_g0_val", o_g0, 32'h0);
    chk("wr_g0_ack", {31'b0, o_ack}, 32'h0);
    drive("wr_e", 0, 1, 4'hE, 32'hFFFF_FFFF, 0, 0, 32'h0, 0);
    chk("wr_e_ack", {31'b0, o_ack}, 32'h0);
    drive("wr_f", 0, 1, 4'hF, 32'hFFFF_FFFF, 0, 0, 32'h0, 0);
    chk("wr_f_ack", {31'b0, o_ack}, 32'h0);

    // PC wrap and priority
    drive("pc_set", 0, 1, 4'h8, 32'hFFFF_FFFC, 0, 0, 32'h0, 0);
    drive("pc_wrap", 0, 0, 4'h0, 32'h0, 1, 0, 32'h0, 0);
    chk("pc_wrap_val", o_pc, 32'h0);
    drive("pc_prio", 0, 1, 4'h8, 32'h0000_0040, 1, 0, 32'h0, 0);
    chk("pc_prio_val", o_pc, 32'h40);

    // IR conflict with parallel PC increment
    drive("pc_100", 0, 1, 4'h8, 32'h0000_0100, 0, 0, 32'h0, 0);
    drive("ir_conf", 0, 1, 4'hD, 32'h0000_1111, 1, 1, 32'h8A00_4005, 0);
    chk("ir_conf_ir", o_ir, 32'h8A00_4005);
    chk("ir_conf_pc", o_pc, 32'h104);
    chk("ir_conf_ack", {31'b0, o_ack}, 32'h0);

    // Temp clear with a concurrent temp write, then reset mid-sequence
    drive("t0_1", 0, 1, 4'h9, 32'h1, 0, 0, 32'h0, 0);
    drive("t1_2", 0, 1, 4'hA, 32'h2, 0, 0, 32'h0, 0);
    drive("t2_3", 0, 1, 4'hB, 32'h3, 0, 0, 32'h0, 0);
    drive("t3_4", 0, 1, 4'hC, 32'h4, 0, 0, 32'h0, 0);
    drive("g1_55", 0, 1, 4'h1, 32'h55, 0, 0, 32'h0, 0);
    drive("tclr", 0, 1, 4'hB, 32'h77, 0, 0, 32'h0, 1);
    chk("tclr_t0", o_t0, 32'h0);
    chk("tclr_t1", o_t1, 32'h0);
    chk("tclr_t2", o_t2, 32'h77);
    chk("tclr_t3", o_t3, 32'h0);
    drive("rst_mid", 1, 1, 4'h1, 32'hABCD_0123, 1, 1, 32'h5, 1);
    chk("rst_mid_g1", o_g1, 32'h0);
    chk("rst_mid_ack", {31'b0, o_ack}, 32'h0);
    chk("rst_mid_pc", o_pc, 32'h100);

    // Randomized cycles
    for (int n = 0; n < 400; n++) begin
      logic [31:0] d;
      d = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFC : $urandom;
      drive("rand", ($urandom_range(0, 39) == 0), ($urandom_range(0, 3) != 0),
            4'($urandom_range(0, 15)), d, ($urandom_range(0, 2) == 0),
            ($urandom_range(0, 3) == 0), $urandom, ($urandom_range(0, 5) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
